// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master core between N_REQ requesters,
// with per-transfer grants, locked multi-word bursts and a lock idle timeout.
module spi_master_arbiter #(
    parameter int N_REQ        = 2,
    parameter int DATA_W       = 16,
    parameter int LEN_W        = 5,
    parameter int CS_W         = 1,
    parameter int LOCK_TIMEOUT = 1023,
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int TW = $clog2(LOCK_TIMEOUT + 1)
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ*LEN_W-1:0]  req_len,
    input  logic [N_REQ*CS_W-1:0]   req_cs,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [OW-1:0]           owner,
    output logic                    locked,
    output logic                    m_start,
    output logic [DATA_W-1:0]       m_data,
    output logic [LEN_W-1:0]        m_len,
    output logic [CS_W-1:0]         m_cs,
    input  logic                    m_idle,
    input  logic [DATA_W-1:0]       m_rx
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic [OW-1:0]       ptr_q, ptr_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic                locked_q, locked_d;
    logic                last_q, last_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [1:0]          wcnt_q, wcnt_d;
    logic [N_REQ-1:0]    req_ready_q, req_ready_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                m_start_q, m_start_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [LEN_W-1:0]    m_len_q, m_len_d;
    logic [CS_W-1:0]     m_cs_q, m_cs_d;

    logic                rr_found;
    logic [OW-1:0]       rr_win;
    logic                gnt;
    logic [OW-1:0]       gnt_idx;
    logic [OW-1:0]       owner_inc;

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!rr_found && req_valid[(int'(ptr_q) + k) % N_REQ]) begin
                rr_found = 1'b1;
                rr_win   = OW'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    assign owner_inc = OW'((int'(owner_q) + 1) % N_REQ);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        locked_d    = locked_q;
        last_d      = last_q;
        tmo_d       = tmo_q;
        wcnt_d      = wcnt_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        m_start_d   = 1'b0;
        m_data_d    = m_data_q;
        m_len_d     = m_len_q;
        m_cs_d      = m_cs_q;
        gnt         = 1'b0;
        gnt_idx     = rr_win;

        unique case (state_q)
            IDLE: begin
                if (locked_q) begin
                    if (req_valid[owner_q]) begin
                        gnt     = 1'b1;
                        gnt_idx = owner_q;
                    end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
                        locked_d = 1'b0;
                        tmo_d    = '0;
                        ptr_d    = owner_inc;
                        m_cs_d   = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end else begin
                    m_cs_d = '0;
                    if (rr_found) begin
                        gnt = 1'b1;
                    end
                end
                if (gnt) begin
                    req_ready_d[gnt_idx] = 1'b1;
                    owner_d  = gnt_idx;
                    m_data_d = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
                    m_len_d  = req_len[int'(gnt_idx)*LEN_W +: LEN_W];
                    m_cs_d   = req_cs[int'(gnt_idx)*CS_W +: CS_W];
                    last_d   = req_last[gnt_idx];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (m_idle) begin
                    m_start_d = 1'b1;
                    wcnt_d    = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // m_idle is stale while start is in flight and one cycle after.
                if (wcnt_q != 2'd2) begin
                    wcnt_d = wcnt_q + 2'd1;
                end else if (m_idle) begin
                    rsp_data_d           = m_rx;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = RESP;
                end
            end
            RESP: begin
                if (!last_q) begin
                    locked_d = 1'b1;
                    tmo_d    = '0;
                end else begin
                    locked_d = 1'b0;
                    ptr_d    = owner_inc;
                    m_cs_d   = '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            locked_q    <= 1'b0;
            last_q      <= 1'b0;
            tmo_q       <= '0;
            wcnt_q      <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            m_start_q   <= 1'b0;
            m_data_q    <= '0;
            m_len_q     <= '0;
            m_cs_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            locked_q    <= locked_d;
            last_q      <= last_d;
            tmo_q       <= tmo_d;
            wcnt_q      <= wcnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            m_start_q   <= m_start_d;
            m_data_q    <= m_data_d;
            m_len_q     <= m_len_d;
            m_cs_q      <= m_cs_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign owner     = owner_q;
    assign locked    = locked_q;
    assign m_start   = m_start_q;
    assign m_data    = m_data_q;
    assign m_len     = m_len_q;
    assign m_cs      = m_cs_q;

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
Shares the single SPI master core (SD-card/peripheral SPI port) between N_REQ requesters, e.g. the SPI-slave register bus and an autonomous slot-polling sequencer. Arbitrates per transfer with round-robin priority and supports locked multi-word bursts. Drives the master's data, length and chip-select inputs and returns received words to the winning requester.

Parameters:
N_REQ, 2, number of requesters (2..8)
DATA_W, 16, transfer word width
LEN_W, 5, width of the length field; the field holds bits-1
CS_W, 1, chip-select vector width
LOCK_TIMEOUT, 1023, idle cycles a locked owner may hold the grant before the lock is forcibly released

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  synchronous reset, active-low
req_valid  in  N_REQ  per-requester transfer request
req_ready  out  N_REQ  request accepted; one-hot, 1-cycle pulse
req_data  in  N_REQ*DATA_W  TX word, requester i at slice i
req_len  in  N_REQ*LEN_W  transfer length minus 1
req_cs  in  N_REQ*CS_W  chip selects to assert
req_last  in  N_REQ  1 = release the grant after this word
rsp_valid  out  N_REQ  one-hot, 1-cycle pulse carrying the RX word
rsp_data  out  DATA_W  RX word, shared across requesters
owner  out  clog2(N_REQ)  current or last grant index
locked  out  1  burst lock held
m_start  out  1  1-cycle start pulse to the SPI master
m_data  out  DATA_W  TX word
m_len  out  LEN_W  length
m_cs  out  CS_W  chip-select vector
m_idle  in  1  master idle
m_rx  in  DATA_W  master RX word, valid when m_idle rises

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer 0, lock cleared, timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, unlocked:
  - Select the first requester with req_valid set, scanning from the pointer upward with wrap-around.
  - Same cycle: pulse req_ready[winner], register data/len/cs/last into m_data/m_len/m_cs, set owner, go to ISSUE.
- IDLE, locked:
  - Only requester `owner` is considered; other requests stay pending and their req_ready stays 0.
  - The timeout counter increments each cycle the owner's req_valid is low.
  - At LOCK_TIMEOUT the lock clears and the pointer advances to owner+1.
- ISSUE: wait for m_idle=1, then pulse m_start for 1 cycle and go to WAIT. m_data, m_len and m_cs stay stable from ISSUE until RESP.
- WAIT:
  - Ignore m_idle on the first cycle after m_start, to cover master start latency.
  - Afterwards, m_idle=1 latches m_rx into rsp_data and moves to RESP.
- RESP:
  - Pulse rsp_valid[owner] for 1 cycle; rsp_data holds its value until the next RESP.
  - If the latched last=0: locked=1, timeout counter cleared.
  - Otherwise: locked=0, pointer = owner+1 mod N_REQ.
  - Return to IDLE.
- m_cs is driven to 0 in IDLE only when unlocked. While locked it holds the owner's cs between words, so the burst stays framed.
- Latency: req_valid to req_ready is 1 cycle from IDLE. RESP to the next m_start is at least 2 cycles.
- Simultaneous requests: exactly one req_ready per grant; losers keep req_valid and are served in round-robin order.
- The pointer advances only on unlocked completion, which prevents starvation.
- req_valid dropping after req_ready: no effect, the transfer completes.
- Reset mid-transfer (sys_rst_n low in WAIT): the FSM returns to IDLE and m_cs returns to 0 immediately; no rsp_valid is issued. The master is reset by the same reset.
- An owner index equal to or greater than N_REQ is unreachable.

Test Plan:
- Single requester: req0 sends data=0xaa55, len=15, cs=1, last=1; the model returns 0x1234 -> one req_ready[0], one m_start, m_data=0xaa55, rsp_valid[0] with rsp_data=0x1234, locked=0, m_cs=0 afterwards.
- Contention: req0 and req1 both valid in the same cycle with pointer=0 -> req0 is served first, then req1; owner sequence 0,1; exactly 2 m_start pulses.
- Fairness: both requesters continuously valid with last=1 for 6 words -> grants alternate 0,1,0,1,0,1.
- Burst lock: req1 sends 3 words, last=0,0,1, while req0 is valid throughout -> req0 is not granted until after the 3rd rsp_valid[1]; m_cs stays at req1's cs for the whole burst.
- Lock timeout: req0 sends last=0, then deasserts; req1 is valid -> after 1023 idle cycles locked falls, req1 is granted on the next cycle, and m_cs drops before m_start.
- Reset in WAIT: sys_rst_n low for 1 cycle mid-transfer -> all outputs 0, no rsp_valid; the next request is served normally with pointer=0.
